// File: rtl/ddr3_ram_arbiter.sv
// Round-robin arbiter sharing one DDR3 core request/response port between two requesters.
// An in-order FIFO of granted port indices steers each core ack back to its issuer.
module ddr3_ram_arbiter #(
    parameter int OUTSTANDING   = 8,
    parameter int OUTSTANDING_W = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [15:0]              inport0_wr_i,
    input  logic                     inport0_rd_i,
    input  logic [31:0]              inport0_addr_i,
    input  logic [15:0]              inport0_req_id_i,
    input  logic [127:0]             inport0_write_data_i,
    output logic                     inport0_accept_o,
    output logic                     inport0_ack_o,
    output logic                     inport0_error_o,
    output logic [127:0]             inport0_read_data_o,
    output logic [15:0]              inport0_resp_id_o,
    input  logic [15:0]              inport1_wr_i,
    input  logic                     inport1_rd_i,
    input  logic [31:0]              inport1_addr_i,
    input  logic [15:0]              inport1_req_id_i,
    input  logic [127:0]             inport1_write_data_i,
    output logic                     inport1_accept_o,
    output logic                     inport1_ack_o,
    output logic                     inport1_error_o,
    output logic [127:0]             inport1_read_data_o,
    output logic [15:0]              inport1_resp_id_o,
    output logic [15:0]              outport_wr_o,
    output logic                     outport_rd_o,
    output logic [31:0]              outport_addr_o,
    output logic [15:0]              outport_req_id_o,
    output logic [127:0]             outport_write_data_o,
    input  logic                     outport_accept_i,
    input  logic                     outport_ack_i,
    input  logic                     outport_error_i,
    input  logic [127:0]             outport_read_data_i,
    input  logic [15:0]              outport_resp_id_i,
    output logic [OUTSTANDING_W:0]   outstanding_o,
    output logic                     unexpected_ack_o
);

    localparam logic [OUTSTANDING_W:0]   FULL_COUNT = (OUTSTANDING_W + 1)'(OUTSTANDING);
    localparam logic [OUTSTANDING_W:0]   COUNT_ONE  = (OUTSTANDING_W + 1)'(1);
    localparam logic [OUTSTANDING_W:0]   COUNT_ZERO = (OUTSTANDING_W + 1)'(0);
    localparam logic [OUTSTANDING_W-1:0] PTR_ONE    = OUTSTANDING_W'(1);

    logic                     req0_s, req1_s;
    logic                     grant_valid_s, grant_port_s;
    logic                     ptr_r, lock_r, lock_port_r;
    logic [15:0]              sel_wr_s;
    logic                     sel_rd_s;
    logic [31:0]              sel_addr_s;
    logic [15:0]              sel_req_id_s;
    logic [127:0]             sel_write_data_s;
    logic                     full_s, empty_s, fwd_en_s, fwd_s, accepted_s, pop_s, head_s;
    logic [OUTSTANDING_W:0]   count_r;
    logic [OUTSTANDING_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [OUTSTANDING-1:0]   fifo_r;
    logic                     unexpected_r;

    assign req0_s = (|inport0_wr_i) | inport0_rd_i;
    assign req1_s = (|inport1_wr_i) | inport1_rd_i;

    // Grant selection: a locked grant wins, otherwise the pointer port has priority.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
        if (lock_r) begin
            grant_valid_s = 1'b1;
            grant_port_s  = lock_port_r;
        end else if (ptr_r ? req1_s : req0_s) begin
            grant_valid_s = 1'b1;
            grant_port_s  = ptr_r;
        end else if (ptr_r ? req0_s : req1_s) begin
            grant_valid_s = 1'b1;
            grant_port_s  = ~ptr_r;
        end else begin
            grant_valid_s = 1'b0;
            grant_port_s  = 1'b0;
        end
    end

    // Request mux onto the core port.
    always_comb begin
        sel_wr_s         = 16'h0;
        sel_rd_s         = 1'b0;
        sel_addr_s       = 32'h0;
        sel_req_id_s     = 16'h0;
        sel_write_data_s = 128'h0;
        case ({grant_valid_s, grant_port_s})
            2'b10: begin
                sel_wr_s         = inport0_wr_i;
                sel_rd_s         = inport0_rd_i;
                sel_addr_s       = inport0_addr_i;
                sel_req_id_s     = inport0_req_id_i;
                sel_write_data_s = inport0_write_data_i;
            end
            2'b11: begin
                sel_wr_s         = inport1_wr_i;
                sel_rd_s         = inport1_rd_i;
                sel_addr_s       = inport1_addr_i;
                sel_req_id_s     = inport1_req_id_i;
                sel_write_data_s = inport1_write_data_i;
            end
            default: begin
                sel_wr_s         = 16'h0;
                sel_rd_s         = 1'b0;
                sel_addr_s       = 32'h0;
                sel_req_id_s     = 16'h0;
                sel_write_data_s = 128'h0;
            end
        endcase
    end

    // A full FIFO blocks forwarding so no response can arrive without a routing slot.
    assign full_s               = (count_r == FULL_COUNT);
    assign empty_s              = (count_r == COUNT_ZERO);
    assign fwd_en_s             = rst_i & ~full_s;
    assign outport_wr_o         = fwd_en_s ? sel_wr_s : 16'h0;
    assign outport_rd_o         = fwd_en_s & sel_rd_s;
    assign outport_addr_o       = rst_i ? sel_addr_s : 32'h0;
    assign outport_req_id_o     = rst_i ? sel_req_id_s : 16'h0;
    assign outport_write_data_o = rst_i ? sel_write_data_s : 128'h0;
    assign fwd_s                = (|outport_wr_o) | outport_rd_o;
    assign accepted_s           = fwd_s & outport_accept_i;
    assign inport0_accept_o     = accepted_s & ~grant_port_s;
    assign inport1_accept_o     = accepted_s & grant_port_s;

    assign pop_s               = rst_i & outport_ack_i & ~empty_s;
    assign head_s              = fifo_r[rd_ptr_r];
    assign inport0_ack_o       = pop_s & ~head_s;
    assign inport1_ack_o       = pop_s & head_s;
    assign inport0_error_o     = inport0_ack_o & outport_error_i;
    assign inport1_error_o     = inport1_ack_o & outport_error_i;
    assign inport0_read_data_o = rst_i ? outport_read_data_i : 128'h0;
    assign inport1_read_data_o = rst_i ? outport_read_data_i : 128'h0;
    assign inport0_resp_id_o   = rst_i ? outport_resp_id_i : 16'h0;
    assign inport1_resp_id_o   = rst_i ? outport_resp_id_i : 16'h0;
    assign outstanding_o       = count_r;
    assign unexpected_ack_o    = unexpected_r;

    // Lock and round-robin pointer state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_r       <= 1'b0;
            lock_r      <= 1'b0;
            lock_port_r <= 1'b0;
        end else if (accepted_s) begin
            lock_r <= 1'b0;
            ptr_r  <= ~grant_port_s;
        end else if (fwd_s) begin
            lock_r      <= 1'b1;
            lock_port_r <= grant_port_s;
        end
    end

    // In-order routing FIFO of granted port indices.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fifo_r   <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (accepted_s) begin
                fifo_r[wr_ptr_r] <= grant_port_s;
                wr_ptr_r         <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accepted_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for a core ack arriving with nothing in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            unexpected_r <= 1'b0;
        end else if (outport_ack_i && empty_s) begin
            unexpected_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_ram_arbiter.sv
// Directed bench for ddr3_ram_arbiter: request-side checks inline, ack routing checked
// by a scoreboard monitor fed from a bench-side model of the in-flight grant order.
module tb_ddr3_ram_arbiter;

    typedef struct {
        logic         port;
        logic [127:0] data;
        logic [15:0]  id;
        logic         err;
    } resp_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [15:0]  inport0_wr_i, inport1_wr_i;
    logic         inport0_rd_i, inport1_rd_i;
    logic [31:0]  inport0_addr_i, inport1_addr_i;
    logic [15:0]  inport0_req_id_i, inport1_req_id_i;
    logic [127:0] inport0_write_data_i, inport1_write_data_i;
    logic         inport0_accept_o, inport0_ack_o, inport0_error_o;
    logic         inport1_accept_o, inport1_ack_o, inport1_error_o;
    logic [127:0] inport0_read_data_o, inport1_read_data_o;
    logic [15:0]  inport0_resp_id_o, inport1_resp_id_o;
    logic [15:0]  outport_wr_o;
    logic         outport_rd_o;
    logic [31:0]  outport_addr_o;
    logic [15:0]  outport_req_id_o;
    logic [127:0] outport_write_data_o;
    logic         outport_accept_i, outport_ack_i, outport_error_i;
    logic [127:0] outport_read_data_i;
    logic [15:0]  outport_resp_id_i;
    logic [3:0]   outstanding_o;
    logic         unexpected_ack_o;

    int    checks = 0;
    int    errors = 0;
    logic  inflight[$];
    resp_t sb[$];

    ddr3_ram_arbiter #(.OUTSTANDING(8), .OUTSTANDING_W(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inport0_wr_i(inport0_wr_i), .inport0_rd_i(inport0_rd_i),
        .inport0_addr_i(inport0_addr_i), .inport0_req_id_i(inport0_req_id_i),
        .inport0_write_data_i(inport0_write_data_i), .inport0_accept_o(inport0_accept_o),
        .inport0_ack_o(inport0_ack_o), .inport0_error_o(inport0_error_o),
        .inport0_read_data_o(inport0_read_data_o), .inport0_resp_id_o(inport0_resp_id_o),
        .inport1_wr_i(inport1_wr_i), .inport1_rd_i(inport1_rd_i),
        .inport1_addr_i(inport1_addr_i), .inport1_req_id_i(inport1_req_id_i),
        .inport1_write_data_i(inport1_write_data_i), .inport1_accept_o(inport1_accept_o),
        .inport1_ack_o(inport1_ack_o), .inport1_error_o(inport1_error_o),
        .inport1_read_data_o(inport1_read_data_o), .inport1_resp_id_o(inport1_resp_id_o),
        .outport_wr_o(outport_wr_o), .outport_rd_o(outport_rd_o),
        .outport_addr_o(outport_addr_o), .outport_req_id_o(outport_req_id_o),
        .outport_write_data_o(outport_write_data_o), .outport_accept_i(outport_accept_i),
        .outport_ack_i(outport_ack_i), .outport_error_i(outport_error_i),
        .outport_read_data_i(outport_read_data_i), .outport_resp_id_i(outport_resp_id_i),
        .outstanding_o(outstanding_o), .unexpected_ack_o(unexpected_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        inport0_wr_i = 16'h0; inport0_rd_i = 1'b0; inport0_addr_i = 32'h0;
        inport0_req_id_i = 16'h0; inport0_write_data_i = 128'h0;
        inport1_wr_i = 16'h0; inport1_rd_i = 1'b0; inport1_addr_i = 32'h0;
        inport1_req_id_i = 16'h0; inport1_write_data_i = 128'h0;
        outport_accept_i = 1'b0; outport_ack_i = 1'b0; outport_error_i = 1'b0;
        outport_read_data_i = 128'h0; outport_resp_id_i = 16'h0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        clear_inputs();
        inflight.delete();
        sb.delete();
        step();
        rst_i = 1'b1;
        step();
    endtask

    // Drive a core response; the expected destination is the oldest grant the model holds.
    task automatic start_ack(input logic [127:0] d, input logic [15:0] id, input logic err);
        resp_t e;
        outport_ack_i = 1'b1; outport_read_data_i = d;
        outport_resp_id_i = id; outport_error_i = err;
        if (inflight.size() > 0) begin
            e.port = inflight.pop_front(); e.data = d; e.id = id; e.err = err;
            sb.push_back(e);
        end
    endtask

    task automatic end_ack();
        outport_ack_i = 1'b0; outport_error_i = 1'b0;
    endtask

    task automatic ack_cycle(input logic [127:0] d, input logic [15:0] id, input logic err);
        start_ack(d, id, err);
        step();
        end_ack();
    endtask

    initial begin
        rst_i = 1'b0;
        clear_inputs();
        fork
            begin
                #1000000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1);
            end
            begin
                resp_t e;
                forever begin
                    @(negedge clk_i);
                    if (rst_i === 1'b1 && (inport0_ack_o || inport1_ack_o)) begin
                        if (sb.size() == 0) begin
                            check("ack_spurious", {inport1_ack_o, inport0_ack_o}, 128'h0);
                        end else begin
                            e = sb.pop_front();
                            check("ack_onehot", {inport1_ack_o, inport0_ack_o},
                                  e.port ? 128'h2 : 128'h1);
                            check("ack_data", e.port ? inport1_read_data_o : inport0_read_data_o, e.data);
                            check("ack_id", e.port ? inport1_resp_id_o : inport0_resp_id_o, e.id);
                            check("ack_err", e.port ? inport1_error_o : inport0_error_o, e.err);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_outstanding", outstanding_o, 0);
        check("rst_unexpected", unexpected_ack_o, 0);
        check("rst_out_rd", outport_rd_o, 0);
        check("rst_out_addr", outport_addr_o, 0);
        rst_i = 1'b1;
        step();

        // Single port read
        inport0_rd_i = 1'b1; inport0_addr_i = 32'h100; inport0_req_id_i = 16'h0011;
        outport_accept_i = 1'b1;
        @(negedge clk_i);
        check("single_rd", outport_rd_o, 1);
        check("single_addr", outport_addr_o, 32'h100);
        check("single_reqid", outport_req_id_o, 16'h0011);
        check("single_acc0", inport0_accept_o, 1);
        check("single_acc1", inport1_accept_o, 0);
        inflight.push_back(1'b0);
        step();
        inport0_rd_i = 1'b0;
        check("single_occ1", outstanding_o, 1);
        step(); step();
        start_ack({16{8'hA5}}, 16'h0011, 1'b0);
        @(negedge clk_i);
        check("single_ack1_low", inport1_ack_o, 0);
        step();
        end_ack();
        check("single_occ0", outstanding_o, 0);

        // Round-robin from reset
        apply_reset();
        inport0_rd_i = 1'b1; inport0_addr_i = 32'h1000;
        inport1_rd_i = 1'b1; inport1_addr_i = 32'h2000;
        outport_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic p;
            p = (i % 2 == 1);
            @(negedge clk_i);
            check("rr_addr", outport_addr_o, p ? 32'h2000 : 32'h1000);
            check("rr_acc0", inport0_accept_o, !p);
            check("rr_acc1", inport1_accept_o, p);
            inflight.push_back(p);
            step();
        end
        clear_inputs();
        check("rr_occ4", outstanding_o, 4);
        for (int i = 0; i < 4; i++) ack_cycle(128'h1000 + 128'(i), 16'h0100 + 16'(i), i == 2);
        check("rr_occ0", outstanding_o, 0);

        // Lock: port1 stalled by the core while port0 arrives
        inport1_wr_i = 16'hFFFF; inport1_addr_i = 32'h3000;
        inport1_write_data_i = {4{32'hDEADBEEF}};
        @(negedge clk_i);
        check("lock_addrA", outport_addr_o, 32'h3000);
        check("lock_wrA", outport_wr_o, 16'hFFFF);
        check("lock_acc1A", inport1_accept_o, 0);
        step();
        inport0_rd_i = 1'b1; inport0_addr_i = 32'h4000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("lock_hold_addr", outport_addr_o, 32'h3000);
            check("lock_hold_data", outport_write_data_o, {4{32'hDEADBEEF}});
            check("lock_hold_acc0", inport0_accept_o, 0);
            step();
        end
        outport_accept_i = 1'b1;
        @(negedge clk_i);
        check("lock_rel_addr", outport_addr_o, 32'h3000);
        check("lock_rel_acc1", inport1_accept_o, 1);
        check("lock_rel_acc0", inport0_accept_o, 0);
        inflight.push_back(1'b1);
        step();
        inport1_wr_i = 16'h0;
        @(negedge clk_i);
        check("lock_next_addr", outport_addr_o, 32'h4000);
        check("lock_next_acc0", inport0_accept_o, 1);
        inflight.push_back(1'b0);
        step();
        clear_inputs();
        check("lock_occ2", outstanding_o, 2);
        ack_cycle(128'h77, 16'h0077, 1'b0);
        ack_cycle(128'h88, 16'h0088, 1'b1);

        // Full FIFO blocks forwarding
        apply_reset();
        inport0_rd_i = 1'b1; inport0_addr_i = 32'h1000;
        inport1_rd_i = 1'b1; inport1_addr_i = 32'h2000;
        outport_accept_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic p;
            p = (i % 2 == 1);
            @(negedge clk_i);
            check("fill_acc1", inport1_accept_o, p);
            inflight.push_back(p);
            step();
        end
        @(negedge clk_i);
        check("full_occ8", outstanding_o, 8);
        check("full_rd", outport_rd_o, 0);
        check("full_acc", {inport1_accept_o, inport0_accept_o}, 0);
        step();
        start_ack(128'hF0, 16'h00F0, 1'b0);
        @(negedge clk_i);
        check("full_pop_rd", outport_rd_o, 0);
        check("full_pop_acc", {inport1_accept_o, inport0_accept_o}, 0);
        step();
        end_ack();
        @(negedge clk_i);
        check("resume_occ7", outstanding_o, 7);
        check("resume_rd", outport_rd_o, 1);
        check("resume_acc", {inport1_accept_o, inport0_accept_o}, 2'b01);
        inflight.push_back(1'b0);
        step();
        inport0_rd_i = 1'b0; inport1_rd_i = 1'b0;
        check("resume_occ8", outstanding_o, 8);
        for (int i = 0; i < 5; i++) ack_cycle(128'h200 + 128'(i), 16'h0200 + 16'(i), 1'b0);
        check("drain_occ3", outstanding_o, 3);

        // Simultaneous push and pop at occupancy 3
        inport1_rd_i = 1'b1; inport1_addr_i = 32'h5000;
        start_ack(128'h300, 16'h0300, 1'b0);
        @(negedge clk_i);
        check("pp_acc1", inport1_accept_o, 1);
        check("pp_acc0", inport0_accept_o, 0);
        inflight.push_back(1'b1);
        step();
        end_ack();
        inport1_rd_i = 1'b0;
        check("pp_occ3", outstanding_o, 3);
        for (int i = 0; i < 3; i++) ack_cycle(128'h400 + 128'(i), 16'h0400 + 16'(i), 1'b0);
        check("pp_occ0", outstanding_o, 0);
        check("pp_sb_empty", sb.size(), 0);

        // Ack with nothing in flight
        outport_ack_i = 1'b1; outport_read_data_i = 128'hBAD;
        @(negedge clk_i);
        check("unexp_route", {inport1_ack_o, inport0_ack_o}, 0);
        check("unexp_before", unexpected_ack_o, 0);
        step();
        end_ack();
        check("unexp_set", unexpected_ack_o, 1);
        step();
        check("unexp_sticky", unexpected_ack_o, 1);
        check("unexp_occ", outstanding_o, 0);

        // Reset asserted mid-burst
        inport0_rd_i = 1'b1; inport0_addr_i = 32'h1000;
        inport1_rd_i = 1'b1; inport1_addr_i = 32'h2000;
        outport_accept_i = 1'b1;
        step(); step();
        check("burst_occ2", outstanding_o, 2);
        rst_i = 1'b0;
        #1;
        check("mid_rst_rd", outport_rd_o, 0);
        check("mid_rst_addr", outport_addr_o, 0);
        check("mid_rst_acc", {inport1_accept_o, inport0_accept_o}, 0);
        check("mid_rst_occ", outstanding_o, 0);
        check("mid_rst_unexp", unexpected_ack_o, 0);
        clear_inputs();
        inflight.delete();
        step();
        rst_i = 1'b1;
        step();
        check("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
